// File: rtl/ahb_master_arb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_master_arb_pkg : AHB-lite codes, FSM states and port ids   (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package ahb_master_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_MISAL = 2'd3
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_arb_pick.sv
// ----------------------------------------------------------------------------
// ahb_arb_pick : data-priority winner select with instruction starvation guard
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_arb_pick
  import ahb_master_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_req_i,
  input  logic  d_req_i,
  input  logic  grant_en_i,
  output logic  grant_valid_o,
  output port_e grant_port_o
);

  localparam int            CW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          contested;

  always_comb begin
    contested     = i_req_i & d_req_i;
    grant_valid_o = i_req_i | d_req_i;
    if (contested) begin
      grant_port_o = (starve_q == CNT_MAX) ? PORT_I : PORT_D;
    end else begin
      grant_port_o = d_req_i ? PORT_D : PORT_I;
    end

    // Only contested data wins age the instruction port; any I grant clears it.
    starve_d = starve_q;
    if (grant_en_i && grant_valid_o) begin
      if (grant_port_o == PORT_I) begin
        starve_d = '0;
      end else if (contested && (starve_q != CNT_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_master_arb.sv
// ----------------------------------------------------------------------------
// ahb_master_arb : two-port (instruction/data) AHB-lite master, one transfer
// outstanding, back-to-back issue on completion.                     rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_master_arb
  import ahb_master_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_e      state_q, state_d;
  port_e       port_q;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic        i_done_q, i_err_q, d_done_q, d_err_q;
  logic [31:0] i_rdata_q, d_rdata_q;

  logic        grant_valid, take, sel_write, sel_ok;
  port_e       grant_port;
  logic [31:0] sel_addr;

  ahb_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk           (clk),
    .rst           (rst),
    .i_req_i       (i_req),
    .d_req_i       (d_req),
    .grant_en_i    (take),
    .grant_valid_o (grant_valid),
    .grant_port_o  (grant_port)
  );

  always_comb begin
    sel_addr  = (grant_port == PORT_D) ? d_addr : i_addr;
    sel_ok    = !is_misaligned(sel_addr);
    sel_write = (grant_port == PORT_D) && d_write && sel_ok;
    take      = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE:  take = grant_valid;
      ST_ADDR:  if (HREADY) state_d = ST_DATA;
      ST_DATA: begin
        // Completion edge doubles as the next arbitration point (no bubble).
        if (HREADY) begin
          take    = grant_valid;
          state_d = ST_IDLE;
        end
      end
      ST_MISAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = sel_ok ? ST_ADDR : ST_MISAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      port_q    <= PORT_I;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      i_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      i_done_q <= 1'b0;
      i_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_err_q  <= 1'b0;
      if (take) begin
        port_q  <= grant_port;
        addr_q  <= sel_addr;
        write_q <= sel_write;
        wdata_q <= sel_write ? d_wdata : 32'h0;
      end
      if (state_q == ST_DATA && HREADY) begin
        if (port_q == PORT_D) begin
          d_done_q  <= 1'b1;
          d_rdata_q <= HRDATA;
          d_err_q   <= HRESP;
        end else begin
          i_done_q  <= 1'b1;
          i_rdata_q <= HRDATA;
          i_err_q   <= HRESP;
        end
      end
      if (state_q == ST_MISAL) begin
        if (port_q == PORT_D) begin
          d_done_q  <= 1'b1;
          d_rdata_q <= '0;
          d_err_q   <= 1'b1;
        end else begin
          i_done_q  <= 1'b1;
          i_rdata_q <= '0;
          i_err_q   <= 1'b1;
        end
      end
    end
  end

  assign HTRANS  = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR   = addr_q;
  assign HWRITE  = write_q;
  assign HWDATA  = wdata_q;
  assign HSIZE   = HSIZE_WORD;
  assign i_done  = i_done_q;
  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_done  = d_done_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_arb.sv
// ----------------------------------------------------------------------------
// tb_ahb_master_arb : directed scenarios plus randomized bus-level scoreboard
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ahb_master_arb;

  localparam int SM = 4;

  logic        clk, rst;
  logic        i_req, d_req, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t expq[$];

  ahb_master_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    nchecks++;
    if ({HTRANS, HADDR, HWRITE, HWDATA, HSIZE, i_done, i_err, i_rdata, d_done, d_err, d_rdata} !==
        {2'b00, 32'h0, 1'b0, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL reset_values: got HTRANS=%b HADDR=%h HWRITE=%b HWDATA=%h HSIZE=%b id=%b ie=%b ird=%h dd=%b de=%b drd=%h",
               HTRANS, HADDR, HWRITE, HWDATA, HSIZE, i_done, i_err, i_rdata, d_done, d_err, d_rdata);
    end
  endtask

  task automatic test_single_read();
    int n = 0;
    i_req = 1'b1; i_addr = 32'h100; HRDATA = 32'h13; HREADY = 1'b1; HRESP = 1'b0;
    for (int c = 1; c <= 10 && n == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        i_req = 1'b0;
        nchecks++;
        if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h100, 1'b0}) begin
          nerr++;
          $display("FAIL read_addr_phase: got HTRANS=%b HADDR=%h HWRITE=%b want 10/00000100/0", HTRANS, HADDR, HWRITE);
        end
      end
      if (c == 2) begin
        nchecks++;
        if (HTRANS !== 2'b00) begin
          nerr++; $display("FAIL read_data_phase_htrans: got %b want 00", HTRANS);
        end
      end
      if (i_done) begin
        n = c;
        nchecks++;
        if ({i_rdata, i_err, d_done} !== {32'h13, 1'b0, 1'b0}) begin
          nerr++; $display("FAIL read_done_data: got rdata=%h err=%b d_done=%b want 00000013/0/0", i_rdata, i_err, d_done);
        end
        HRDATA = 32'hFFFF_FFFF;
      end
    end
    nchecks++;
    if (n != 3) begin
      nerr++; $display("FAIL read_latency: got %0d cycles want 3", n);
    end
    @(negedge clk);
    nchecks++;
    if ({i_done, i_rdata} !== {1'b0, 32'h13}) begin
      nerr++; $display("FAIL read_hold: got done=%b rdata=%h want 0/00000013", i_done, i_rdata);
    end
  endtask

  task automatic test_wait_write();
    int n = 0;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; HREADY = 1'b1; HRDATA = 32'h55;
    for (int c = 1; c <= 12 && n == 0; c++) begin
      @(negedge clk);
      HREADY = !(c == 2 || c == 3);
      if (c == 1) begin
        d_req = 1'b0;
        nchecks++;
        if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h2000, 1'b1}) begin
          nerr++; $display("FAIL write_addr_phase: got HTRANS=%b HADDR=%h HWRITE=%b want 10/00002000/1", HTRANS, HADDR, HWRITE);
        end
      end
      if (c >= 2 && c <= 4) begin
        nchecks++;
        if ({HTRANS, HWDATA} !== {2'b00, 32'hDEAD_BEEF}) begin
          nerr++; $display("FAIL write_hwdata_c%0d: got HTRANS=%b HWDATA=%h want 00/deadbeef", c, HTRANS, HWDATA);
        end
      end
      if (d_done) begin
        n = c;
        nchecks++;
        if ({d_err, i_done} !== 2'b00) begin
          nerr++; $display("FAIL write_done_err: got d_err=%b i_done=%b want 0/0", d_err, i_done);
        end
      end
    end
    nchecks++;
    if (n != 5) begin
      nerr++; $display("FAIL write_wait_latency: got %0d cycles want 5", n);
    end
    d_write = 1'b0;
  endtask

  task automatic test_starve();
    int k = 0, last = 0;
    bit port, exp_port;
    do_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h2000; d_write = 1'b0;
    HREADY = 1'b1; HRDATA = 32'h66;
    for (int c = 1; c <= 60 && k < 10; c++) begin
      @(negedge clk);
      if (HTRANS == 2'b10) begin
        port     = (HADDR == 32'h2000);
        exp_port = ((k % (SM + 1)) == SM) ? 1'b0 : 1'b1;
        nchecks++;
        if (port !== exp_port) begin
          nerr++; $display("FAIL starve_order_%0d: got port %s want %s", k, port ? "D" : "I", exp_port ? "D" : "I");
        end
        if (k > 0) begin
          nchecks++;
          if (c - last != 2) begin
            nerr++; $display("FAIL starve_gap_%0d: got %0d cycles between NONSEQ want 2", k, c - last);
          end
        end
        last = c;
        k++;
      end
    end
    nchecks++;
    if (k != 10) begin
      nerr++; $display("FAIL starve_timeout: got %0d grants want 10", k);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_misaligned();
    int n = 0;
    d_req = 1'b1; d_addr = 32'h2002; d_write = 1'b0; HRDATA = 32'hAAAA_5555; HREADY = 1'b1;
    for (int c = 1; c <= 8 && n == 0; c++) begin
      @(negedge clk);
      if (c == 1) d_req = 1'b0;
      nchecks++;
      if (HTRANS !== 2'b00) begin
        nerr++; $display("FAIL misal_htrans_c%0d: got %b want 00", c, HTRANS);
      end
      if (d_done) begin
        n = c;
        nchecks++;
        if ({d_err, d_rdata} !== {1'b1, 32'h0}) begin
          nerr++; $display("FAIL misal_done: got err=%b rdata=%h want 1/00000000", d_err, d_rdata);
        end
      end
    end
    nchecks++;
    if (n != 2) begin
      nerr++; $display("FAIL misal_latency: got %0d cycles want 2", n);
    end
  endtask

  task automatic test_hresp();
    int n = 0;
    i_req = 1'b1; i_addr = 32'h400; HRDATA = 32'h1234; HRESP = 1'b0; HREADY = 1'b1;
    for (int c = 1; c <= 10 && n == 0; c++) begin
      @(negedge clk);
      if (c == 1) i_req = 1'b0;
      HRESP = (c == 2);
      if (i_done) begin
        n = c;
        nchecks++;
        if ({i_err, i_rdata} !== {1'b1, 32'h1234}) begin
          nerr++; $display("FAIL hresp_done: got err=%b rdata=%h want 1/00001234", i_err, i_rdata);
        end
      end
    end
    nchecks++;
    if (n != 3) begin
      nerr++; $display("FAIL hresp_latency: got %0d cycles want 3", n);
    end
    HRESP = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    i_req = 1'b1; i_addr = 32'h300; HRDATA = 32'h77; HREADY = 1'b1;
    @(negedge clk); i_req = 1'b0;
    @(negedge clk); HREADY = 1'b0;
    #2 rst = 1'b1;
    #1;
    nchecks++;
    if ({HTRANS, HADDR, HWRITE, HWDATA, HSIZE, i_done, i_err, i_rdata, d_done, d_err, d_rdata} !==
        {2'b00, 32'h0, 1'b0, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL rst_mid_values: got HTRANS=%b HADDR=%h HWDATA=%h id=%b ird=%h dd=%b drd=%h",
               HTRANS, HADDR, HWDATA, i_done, i_rdata, d_done, d_rdata);
    end
    HREADY = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nchecks++;
      if ({i_done, d_done, HTRANS} !== 4'b0000) begin
        nerr++; $display("FAIL rst_mid_no_done: got i_done=%b d_done=%b HTRANS=%b want 0/0/00", i_done, d_done, HTRANS);
      end
    end
    i_req = 1'b1; i_addr = 32'h104; HRDATA = 32'h99;
    for (int c = 1; c <= 10 && n == 0; c++) begin
      @(negedge clk);
      if (c == 1) i_req = 1'b0;
      if (i_done) begin
        n = c;
        nchecks++;
        if ({i_rdata, i_err} !== {32'h99, 1'b0}) begin
          nerr++; $display("FAIL rst_mid_after: got rdata=%h err=%b want 00000099/0", i_rdata, i_err);
        end
      end
    end
    nchecks++;
    if (n != 3) begin
      nerr++; $display("FAIL rst_mid_latency: got %0d cycles want 3", n);
    end
  endtask

  // Random segments: fixed requester mix, random wait states/data/responses.
  // A bus-level slave view predicts completions; grant order follows the
  // "every (SM+1)-th contested grant goes to I" rule from a fresh reset.
  task automatic test_random();
    int          mask, target, ndone, ngrant, drain;
    bit          dphase, dport, exp_port, dw;
    logic [31:0] ia, da, dwd, rd;
    logic        er;
    exp_t        e;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      expq.delete();
      mask   = $urandom_range(1, 3);
      target = $urandom_range(6, 12);
      ia     = 32'h0000_1000 + ($urandom_range(0, 1023) << 2);
      da     = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
      dw     = $urandom_range(0, 1);
      dwd    = $urandom();
      ndone = 0; ngrant = 0; drain = 0; dphase = 1'b0; dport = 1'b0;
      i_addr = ia; d_addr = da; d_write = dw; d_wdata = dwd;
      i_req = mask[0]; d_req = mask[1];
      for (int c = 0; c < 1500 && drain < 12; c++) begin
        @(negedge clk);
        if (i_done || d_done) begin
          nchecks++;
          if (expq.size() == 0 || (i_done && d_done)) begin
            nerr++; $display("FAIL rand_unexpected_done seg%0d: i_done=%b d_done=%b pending=%0d", seg, i_done, d_done, expq.size());
          end else begin
            e  = expq.pop_front();
            rd = d_done ? d_rdata : i_rdata;
            er = d_done ? d_err : i_err;
            if ({d_done, rd, er} !== {e.port, e.rdata, e.err}) begin
              nerr++;
              $display("FAIL rand_done seg%0d: got port=%0d rdata=%h err=%b want port=%0d rdata=%h err=%b",
                       seg, d_done, rd, er, e.port, e.rdata, e.err);
            end
          end
          ndone++;
        end
        if (ndone >= target) begin
          i_req = 1'b0; d_req = 1'b0; drain++;
        end
        HREADY = (ndone >= target) ? 1'b1 : ($urandom_range(0, 3) != 0);
        HRDATA = $urandom();
        HRESP  = ($urandom_range(0, 7) == 0);
        #1;
        if (dphase && HREADY) begin
          nchecks++;
          if (HWDATA !== ((dport && dw) ? dwd : 32'h0)) begin
            nerr++; $display("FAIL rand_hwdata seg%0d: got %h want %h", seg, HWDATA, (dport && dw) ? dwd : 32'h0);
          end
          e.port = dport; e.rdata = HRDATA; e.err = HRESP;
          expq.push_back(e);
          dphase = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          if (mask == 1)      exp_port = 1'b0;
          else if (mask == 2) exp_port = 1'b1;
          else                exp_port = ((ngrant % (SM + 1)) == SM) ? 1'b0 : 1'b1;
          nchecks++;
          if ({HADDR, HWRITE, HSIZE} !== {exp_port ? da : ia, exp_port & dw, 3'b010}) begin
            nerr++;
            $display("FAIL rand_grant seg%0d #%0d: got HADDR=%h HWRITE=%b HSIZE=%b want HADDR=%h HWRITE=%b",
                     seg, ngrant, HADDR, HWRITE, HSIZE, exp_port ? da : ia, exp_port & dw);
          end
          dphase = 1'b1; dport = exp_port; ngrant++;
        end
      end
      nchecks++;
      if (drain < 12 || expq.size() != 0 || ndone != ngrant) begin
        nerr++; $display("FAIL rand_drain seg%0d: done=%0d grants=%0d pending=%0d drain=%0d", seg, ndone, ngrant, expq.size(), drain);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wait_write();
    test_starve();
    test_misaligned();
    test_hresp();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

`default_nettype wire
